// File: rtl/two_gates_pkg.sv
// Shared constants for the two-gate observation cell.
package two_gates_pkg;

  localparam int TWO_GATES_CNT_W_DEFAULT = 8;

endpackage

// File: rtl/two_gates_net.sv
// OR-then-AND gate pair; kept as explicit primitive instances so the
// netlist shows both gates until the optimiser chooses to fold them.
module two_gates_net (
  input  logic a,
  input  logic b,
  output logic c
);

  logic g1;

  or  u_g1 (g1, a, b);
  and u_g2 (c, a, g1);

endmodule

// File: rtl/two_gates_unit.sv
// Two-gate cell with a registered copy of its output and a saturating
// counter of registered output transitions.
module two_gates_unit
  import two_gates_pkg::*;
#(
  parameter int CNT_W = TWO_GATES_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  output logic             c,
  output logic             c_q,
  output logic [CNT_W-1:0] toggles
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic changed;
  logic at_max;

  two_gates_net u_net (
    .a (a),
    .b (b),
    .c (c)
  );

  assign changed = (c != c_q);
  assign at_max  = (toggles == CNT_MAX);

  // The count is taken against the old c_q, so it lands on the same edge
  // that c_q picks up the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q     <= 1'b0;
      toggles <= '0;
    end else begin
      c_q <= c;
      if (changed && !at_max) begin
        toggles <= toggles + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_two_gates_unit.sv
// Bench for two_gates_unit: combinational table, directed multi-cycle
// sequences and a random run checked against a transition-history model.
module tb_two_gates_unit;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic       a;
  logic       b;
  logic       c;
  logic       c_q;
  logic [7:0] toggles;
  logic       c_s;
  logic       c_q_s;
  logic [1:0] toggles_s;

  int errors;
  int checks;

  logic [31:0] exp_q[$];
  bit          hist[$];

  typedef struct {
    logic a;
    logic b;
    logic c;
  } comb_vec_t;

  comb_vec_t comb_tab[4];

  two_gates_unit #(.CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .c       (c),
    .c_q     (c_q),
    .toggles (toggles)
  );

  two_gates_unit #(.CNT_W(2)) dut_s (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .c       (c_s),
    .c_q     (c_q_s),
    .toggles (toggles_s)
  );

  // Clock / reset block: clock held low until clk_en is raised.
  initial begin
    clk = 1'b0;
    forever begin
      #10;
      if (clk_en) clk = ~clk;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: c_q is the last c seen at a non-reset edge; toggles is the
  // number of value changes in that history (starting from 0), capped.
  task automatic model_edge(input bit rst_v, input bit c_v);
    int trans;
    bit prev;
    if (rst_v) hist.delete();
    else hist.push_back(c_v);
    trans = 0;
    prev  = 1'b0;
    foreach (hist[i]) begin
      if (hist[i] != prev) trans++;
      prev = hist[i];
    end
    exp_q.push_back((hist.size() > 0) ? 32'(hist[hist.size()-1]) : 32'd0);
    exp_q.push_back(32'((trans > 255) ? 255 : trans));
    exp_q.push_back(32'((trans > 3) ? 3 : trans));
  endtask

  // Driver: apply inputs just after an edge, check c mid-cycle, then
  // check the registered outputs just after the next edge.
  task automatic cycle(input logic a_v, input logic b_v, input logic rst_v);
    logic [31:0] e;
    a   = a_v;
    b   = b_v;
    rst = rst_v;
    #5;
    check("c", 32'(c), 32'(a_v));
    check("c_s", 32'(c_s), 32'(a_v));
    @(posedge clk);
    #1;
    model_edge(rst_v, a_v);
    e = exp_q.pop_front();
    check("c_q", 32'(c_q), e);
    check("c_q_s", 32'(c_q_s), e);
    e = exp_q.pop_front();
    check("toggles", 32'(toggles), e);
    e = exp_q.pop_front();
    check("toggles_s", 32'(toggles_s), e);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clk_en = 1'b0;
    rst    = 1'b1;
    a      = 1'b0;
    b      = 1'b0;

    comb_tab[0] = '{a: 1'b0, b: 1'b0, c: 1'b0};
    comb_tab[1] = '{a: 1'b1, b: 1'b0, c: 1'b1};
    comb_tab[2] = '{a: 1'b1, b: 1'b1, c: 1'b1};
    comb_tab[3] = '{a: 1'b0, b: 1'b1, c: 1'b0};

    // Combinational truth table with the clock stopped.
    for (int i = 0; i < 4; i++) begin
      a = comb_tab[i].a;
      b = comb_tab[i].b;
      #10;
      check($sformatf("comb_c[%0d]", i), 32'(c), 32'(comb_tab[i].c));
    end

    // Start the clock aligned so drivers run just after rising edges.
    clk_en = 1'b1;
    @(posedge clk);
    #1;

    // Reset held two cycles with a=1, then release: one transition.
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    check("reset_toggles", 32'(toggles), 32'd0);
    cycle(1'b1, 1'b0, 1'b0);
    check("release_c_q", 32'(c_q), 32'd1);
    check("release_toggles", 32'(toggles), 32'd1);

    // Transition count over a=0,1,1,0,1.
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    check("seq_toggles", 32'(toggles), 32'd3);

    // Saturation of the 2-bit counter with a toggling every cycle.
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'(i % 2 == 0), 1'($urandom_range(0, 1)), 1'b0);
    check("sat_toggles_s", 32'(toggles_s), 32'd3);
    check("sat_toggles", 32'(toggles), 32'd10);

    // Reset mid-run at toggles=5, then counting resumes.
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'(i % 2 == 0), 1'b0, 1'b0);
    check("mid_pre_toggles", 32'(toggles), 32'd5);
    cycle(1'b0, 1'b0, 1'b1);
    check("mid_rst_toggles", 32'(toggles), 32'd0);
    check("mid_rst_c_q", 32'(c_q), 32'd0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check("mid_resume_toggles", 32'(toggles), 32'd2);

    // b independence: a held high, b toggling.
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'(i % 2), 1'b0);
    check("b_indep_toggles", 32'(toggles), 32'd1);

    // Random run with occasional resets.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 39) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
